// File: rtl/tx_uart.sv
// ----------------------------------------------------------------------------
// tx_uart : 8N1 serial transmitter with a runtime-programmable baud divisor
//           and a small byte FIFO.
//
// The host pushes bytes with a one-cycle tx_start strobe. Queued bytes go out
// LSB first, framed by a start bit (0) and a stop bit (1). Frames are sent
// back-to-back with no idle gap. Each bit lasts baud_div+1 clk cycles, which
// is the same divisor convention as the companion receiver.
//
// Optional feature (compile-time macro TX_UART_PARITY_EN):
//   When defined, a parity bit is inserted between data bit 7 and the stop
//   bit. The parity bit is the XOR of the data bits XOR PARITY_ODD. When the
//   macro is undefined, the block is plain 8N1 and PARITY_ODD has no effect.
//
// Parameters:
//   FIFO_AW     log2 of FIFO depth (1..4)
//   PARITY_ODD  parity sense, 0 = even, 1 = odd (parity build only)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   baud_div    bit period minus one, in clk cycles
//   tx_byte     byte to enqueue
//   tx_start    one-cycle write strobe
//   tx_full     FIFO full
//   tx_overrun  one-cycle pulse when a write is dropped
//   tx_busy     frame on the wire or FIFO non-empty
//   tx_pin      serial line, idles high
// ----------------------------------------------------------------------------
module tx_uart #(
    parameter int FIFO_AW    = 2,
    parameter int PARITY_ODD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] baud_div,
    input  logic [7:0]  tx_byte,
    input  logic        tx_start,
    output logic        tx_full,
    output logic        tx_overrun,
    output logic        tx_busy,
    output logic        tx_pin
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = DEPTH[FIFO_AW:0];

    // Reject illegal parameter values at elaboration time.
    if ((FIFO_AW < 1) || (FIFO_AW > 4) || (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : gBadParam
        $error("tx_uart: FIFO_AW must be 1..4 and PARITY_ODD must be 0 or 1");
    end

`ifdef TX_UART_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    logic [7:0]         fifoMem [DEPTH];
    logic [FIFO_AW-1:0] wrPtr_q;
    logic [FIFO_AW-1:0] rdPtr_q;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;
    logic               popEn;
    logic               wrAccept;
    logic               wrDrop;
    logic [7:0]         headByte;

    state_t             state_q;
    logic [15:0]        timer_q;
    logic [2:0]         bitIdx_q;
    logic [7:0]         shift_q;
`ifdef TX_UART_PARITY_EN
    logic               parity_q;
`endif

    // FIFO control. A pop happens when the FSM is idle, or at the very end of
    // a stop bit, and there is something queued. A write into a full FIFO is
    // still accepted when a pop frees a slot in the same cycle.
    always_comb begin
        headByte = fifoMem[rdPtr_q];
        popEn    = (count_q != '0) &&
                   ((state_q == IDLE) || ((state_q == STOP) && (timer_q == 16'd0)));
        wrAccept = tx_start && ((count_q != DEPTH_C) || popEn);
        wrDrop   = tx_start && !wrAccept;
        count_d  = count_q;
        if (wrAccept && !popEn) begin
            count_d = count_q + (FIFO_AW + 1)'(1);
        end else if (!wrAccept && popEn) begin
            count_d = count_q - (FIFO_AW + 1)'(1);
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            fifoMem[wrPtr_q] <= tx_byte;
        end
    end

    // Pointers, occupancy and the registered full/overrun flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            tx_full    <= 1'b0;
            tx_overrun <= 1'b0;
        end else begin
            if (wrAccept) begin
                wrPtr_q <= wrPtr_q + FIFO_AW'(1);
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + FIFO_AW'(1);
            end
            count_q    <= count_d;
            tx_full    <= (count_d == DEPTH_C);
            tx_overrun <= wrDrop;
        end
    end

    // Transmit FSM. The bit timer counts down baud_div..0, so every bit holds
    // baud_div+1 cycles; baud_div is only sampled when the timer is reloaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            timer_q  <= 16'd0;
            bitIdx_q <= 3'd0;
            shift_q  <= 8'd0;
            tx_pin   <= 1'b1;
`ifdef TX_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // Free-running countdown; any reload below takes priority.
            if (timer_q != 16'd0) begin
                timer_q <= timer_q - 16'd1;
            end
            case (state_q)
                IDLE: begin
                    tx_pin <= 1'b1;
                    if (popEn) begin
                        shift_q <= headByte;
`ifdef TX_UART_PARITY_EN
                        parity_q <= (^headByte) ^ (PARITY_ODD != 0);
`endif
                        timer_q <= baud_div;
                        tx_pin  <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (timer_q == 16'd0) begin
                        tx_pin   <= shift_q[0];
                        timer_q  <= baud_div;
                        bitIdx_q <= 3'd0;
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (timer_q == 16'd0) begin
                        timer_q <= baud_div;
                        if (bitIdx_q != 3'd7) begin
                            // shift_q[1] is the bit that becomes the new LSB.
                            shift_q  <= shift_q >> 1;
                            tx_pin   <= shift_q[1];
                            bitIdx_q <= bitIdx_q + 3'd1;
                        end else begin
`ifdef TX_UART_PARITY_EN
                            tx_pin  <= parity_q;
                            state_q <= PARITY;
`else
                            tx_pin  <= 1'b1;
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef TX_UART_PARITY_EN
                PARITY: begin
                    if (timer_q == 16'd0) begin
                        tx_pin  <= 1'b1;
                        timer_q <= baud_div;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (timer_q == 16'd0) begin
                        if (popEn) begin
                            // Next frame starts straight after this stop bit.
                            shift_q <= headByte;
`ifdef TX_UART_PARITY_EN
                            parity_q <= (^headByte) ^ (PARITY_ODD != 0);
`endif
                            timer_q <= baud_div;
                            tx_pin  <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_pin  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_busy = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_tx_uart.sv
// ----------------------------------------------------------------------------
// tb_tx_uart : directed testbench for tx_uart.
//
// Stimulus pushes each byte it expects on the wire into a scoreboard queue.
// A separate monitor decodes tx_pin cycle by cycle, checks that every bit is
// held for the full bit period, and compares each complete frame with the
// head of the queue. Timing, flag and reset behaviour is checked directly by
// the stimulus process.
//
// If TX_UART_PARITY_EN is defined for the build, the bench expects 11-bit
// frames with even parity (DUT default PARITY_ODD = 0).
// ----------------------------------------------------------------------------
module tb_tx_uart;

`ifdef TX_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic PAR_ODD = 1'b0;

    logic        clk;
    logic        rst;
    logic [15:0] baud_div;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        tx_full;
    logic        tx_overrun;
    logic        tx_busy;
    logic        tx_pin;

    int          vectors;
    int          miscompares;
    int          cyc;
    int          framesSeen;
    bit          monOn;
    logic [7:0]  expQ [$];
    int          startTimes [$];

    tx_uart dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .tx_byte    (tx_byte),
        .tx_start   (tx_start),
        .tx_full    (tx_full),
        .tx_overrun (tx_overrun),
        .tx_busy    (tx_busy),
        .tx_pin     (tx_pin)
    );

    // 100 MHz-style clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to timestamp frame starts.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected on-wire frame, bit 0 first (start bit).
    function automatic logic [FRAME_BITS-1:0] expFrame(input logic [7:0] b);
`ifdef TX_UART_PARITY_EN
        return {1'b1, (^b) ^ PAR_ODD, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Called on a negedge: strobe one byte for exactly one rising edge and
    // return on the following negedge.
    task automatic applyStimulus(input logic [7:0] b, input bit expectFrame);
        tx_byte  = b;
        tx_start = 1'b1;
        if (expectFrame) begin
            expQ.push_back(b);
        end
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic waitBusyLow(input int limit, output int n);
        n = 0;
        while (tx_busy && (n < limit)) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: decode frames from tx_pin and compare against the scoreboard.
    initial begin
        logic [FRAME_BITS-1:0] got;
        logic [FRAME_BITS-1:0] want;
        logic [7:0]            expB;
        bit                    glitch;
        bit                    aborted;
        int                    period;
        forever begin
            @(negedge clk);
            if (monOn && rst && (tx_pin == 1'b0)) begin
                startTimes.push_back(cyc);
                period  = int'(baud_div) + 1;
                got     = '0;
                glitch  = 1'b0;
                aborted = 1'b0;
                for (int b = 0; b < FRAME_BITS; b++) begin
                    for (int s = 0; s < period; s++) begin
                        if (!((b == 0) && (s == 0))) begin
                            @(negedge clk);
                        end
                        if (!rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (s == 0) begin
                            got[b] = tx_pin;
                        end else if (tx_pin !== got[b]) begin
                            glitch = 1'b1;
                        end
                    end
                    if (aborted) begin
                        break;
                    end
                end
                if (!aborted) begin
                    framesSeen++;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedFrame", 32'(got), 32'h0);
                    end else begin
                        expB = expQ.pop_front();
                        want = expFrame(expB);
                        checkOutput("frameBits", 32'(got), 32'(want));
                        checkOutput("bitHold", 32'(glitch), 32'h0);
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int n;
        int s0;
        int tW;
        int frames0;
        bit allHigh;
        logic [FRAME_BITS-1:0] f;
        int idx;

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        framesSeen  = 0;
        monOn       = 1'b1;
        rst         = 1'b1;
        baud_div    = 16'd3;
        tx_byte     = 8'h00;
        tx_start    = 1'b0;

        // Reset state.
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetPin", 32'(tx_pin), 32'h1);
        checkOutput("resetBusy", 32'(tx_busy), 32'h0);
        checkOutput("resetFull", 32'(tx_full), 32'h0);
        checkOutput("resetOverrun", 32'(tx_overrun), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x55 at baud_div=3.
        $display("[TB] single byte");
        applyStimulus(8'h55, 1'b1);
        tW = cyc;
        checkOutput("singleBusyHigh", 32'(tx_busy), 32'h1);
        waitBusyLow(400, n);
        checkOutput("singleBusyCycles", 32'(n), 32'(1 + FRAME_BITS * 4));
        checkOutput("singleStartLatency", 32'(startTimes[$]), 32'(tW + 1));
        repeat (3) @(negedge clk);

        // Back-to-back frames 0xA5, 0x3C.
        $display("[TB] back-to-back");
        s0 = startTimes.size();
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        waitBusyLow(400, n);
        checkOutput("b2bBusyCycles", 32'(n), 32'(FRAME_BITS * 8));
        checkOutput("b2bFrameCount", 32'(startTimes.size() - s0), 32'h2);
        if (startTimes.size() >= s0 + 2) begin
            checkOutput("b2bStartGap", 32'(startTimes[s0 + 1] - startTimes[s0]),
                        32'(FRAME_BITS * 4));
        end
        repeat (3) @(negedge clk);

        // Overrun at baud_div=9, then a write landing on the pop edge.
        $display("[TB] overrun");
        baud_div = 16'd9;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1);
        end
        checkOutput("fullAfter5", 32'(tx_full), 32'h1);
        checkOutput("noOverrunAfter5", 32'(tx_overrun), 32'h0);
        applyStimulus(8'h06, 1'b0);
        checkOutput("overrunPulse", 32'(tx_overrun), 32'h1);
        checkOutput("fullAtDrop", 32'(tx_full), 32'h1);
        @(negedge clk);
        checkOutput("overrunOneCycle", 32'(tx_overrun), 32'h0);
        repeat (FRAME_BITS * 10 - 6) @(negedge clk);
        checkOutput("fullBeforePop", 32'(tx_full), 32'h1);
        applyStimulus(8'h07, 1'b1);
        checkOutput("writeOnPopNoOverrun", 32'(tx_overrun), 32'h0);
        checkOutput("writeOnPopStillFull", 32'(tx_full), 32'h1);
        waitBusyLow(2000, n);
        checkOutput("overrunDrain", 32'(tx_busy), 32'h0);
        repeat (3) @(negedge clk);

        // Mid-frame divisor change: start bit at 1, then 7.
        $display("[TB] baud_div change");
        monOn    = 1'b0;
        baud_div = 16'd1;
        @(negedge clk);
        applyStimulus(8'hA5, 1'b0);
        f = expFrame(8'hA5);
        for (int k = 1; k <= 2 + 8 * (FRAME_BITS - 1); k++) begin
            @(negedge clk);
            if (k == 1) begin
                baud_div = 16'd7;
            end
            idx = (k < 3) ? 0 : 1 + (k - 3) / 8;
            checkOutput($sformatf("baudChgBit%0d", k), 32'(tx_pin), 32'(f[idx]));
        end
        @(negedge clk);
        checkOutput("baudChgBusyLow", 32'(tx_busy), 32'h0);
        monOn = 1'b1;
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of 0xF0 with two bytes queued.
        $display("[TB] reset mid-frame");
        baud_div = 16'd3;
        @(negedge clk);
        applyStimulus(8'hF0, 1'b1);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        repeat (16) @(negedge clk);
        checkOutput("preResetBit3", 32'(tx_pin), 32'h0);
        checkOutput("preResetBusy", 32'(tx_busy), 32'h1);
        frames0 = framesSeen;
        rst = 1'b0;
        expQ.delete();
        #1;
        checkOutput("resetAbortPin", 32'(tx_pin), 32'h1);
        checkOutput("resetAbortBusy", 32'(tx_busy), 32'h0);
        checkOutput("resetAbortFull", 32'(tx_full), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        allHigh = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if ((tx_pin !== 1'b1) || (tx_busy !== 1'b0)) begin
                allHigh = 1'b0;
            end
        end
        checkOutput("postResetIdle", 32'(allHigh), 32'h1);
        checkOutput("postResetNoFrames", 32'(framesSeen - frames0), 32'h0);

        // Fastest rate, baud_div=0.
        $display("[TB] baud_div 0 and 1");
        baud_div = 16'd0;
        @(negedge clk);
        applyStimulus(8'h80, 1'b1);
        waitBusyLow(200, n);
        checkOutput("div0BusyCycles", 32'(n), 32'(1 + FRAME_BITS));
        repeat (2) @(negedge clk);

        // 0x07 at baud_div=1 (odd weight; exercises the parity bit if built).
        baud_div = 16'd1;
        @(negedge clk);
        applyStimulus(8'h07, 1'b1);
        waitBusyLow(200, n);
        checkOutput("div1BusyCycles", 32'(n), 32'(1 + FRAME_BITS * 2));
        repeat (4) @(negedge clk);

        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tx_uart.md
Name: tx_uart

Overview:
Serial 8N1 transmitter with a runtime-programmable baud divisor. It is the transmit-side companion to the team's UART receiver and uses the same baud_div convention, so both ends share one divisor value. A small byte FIFO decouples the host from the wire: the host pushes bytes with a one-cycle strobe, and frames go out back-to-back with no idle gap between them.

Parameters:
FIFO_AW, 2, log2 of FIFO depth (default depth 4 bytes); legal values 1..4.
PARITY_ODD, 0, parity sense; 0 = even, 1 = odd. Used only when TX_UART_PARITY_EN is defined.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  asynchronous active-low reset.
baud_div  input  16  bit period minus one, in clk cycles; each bit lasts baud_div+1 cycles.
tx_byte  input  8  byte to enqueue.
tx_start  input  1  one-cycle write strobe; pushes tx_byte into the FIFO.
tx_full  output  1  FIFO full; the host must not strobe.
tx_overrun  output  1  one-cycle pulse when a write is dropped.
tx_busy  output  1  high while a frame is on the wire or the FIFO is non-empty.
tx_pin  output  1  serial line; idles high.

Behaviour:
- Reset (rst low, async): tx_pin=1, tx_busy=0, tx_full=0, tx_overrun=0; FIFO pointers and count cleared; state=IDLE. Reset mid-frame aborts the frame at once, with the line forced high and queued bytes discarded.
- FIFO: depth 2^FIFO_AW; write pointer, read pointer and a count of width FIFO_AW+1; pointers wrap modulo depth.
- Write with tx_start=1:
  - Not full: accepted.
  - Full, same cycle as an FSM pop: accepted; count unchanged.
  - Full, no pop: dropped; tx_overrun=1 for that one cycle only.
- tx_full = (count == depth), registered from count.
- tx_busy = (state != IDLE) | (count != 0).
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- IDLE:
  - tx_pin=1.
  - If count != 0: pop the head into shift register sh; load timer=baud_div; tx_pin<=0; go to START.
  - A byte written at edge E0 into an empty FIFO drives tx_pin low at edge E1, i.e. one cycle later.
- START:
  - Timer counts down to 0.
  - At 0: tx_pin<=sh[0]; timer<=baud_div; bit index<=0; go to DATA.
- DATA, LSB first:
  - At timer 0 with index<7: shift sh right; drive next bit; index+1; reload timer.
  - At timer 0 with index==7: tx_pin<=1; reload timer; go to STOP.
- STOP:
  - At timer 0 with count != 0: pop the next byte; tx_pin<=0; reload timer; go to START. There is no idle cycle between frames.
  - At timer 0 with count == 0: go to IDLE.
- Frame timing: 10*(baud_div+1) cycles per frame. Every bit, start and stop included, holds exactly baud_div+1 cycles.
- baud_div is sampled only at each timer reload; a change mid-bit takes effect from the next bit.
- baud_div=0 is legal: one cycle per bit.
- The timer is 16 bits and decrements only when non-zero; it never wraps.

Optional Feature:
Macro TX_UART_PARITY_EN.
- Defined: after data bit 7 the FSM enters PARITY.
  - It drives the parity bit for baud_div+1 cycles, then goes to STOP.
  - The parity bit is the XOR of the 8 data bits, captured at pop, XOR PARITY_ODD.
  - Frame = 11*(baud_div+1) cycles.
- Undefined: no PARITY state, no parity register, PARITY_ODD ignored; 8N1 exactly as above.

Test Plan:
- Single byte, baud_div=3, write 0x55 at edge E0 -> tx_pin low at E1 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles; tx_busy falls 40 cycles after E1.
- Back-to-back, baud_div=3, write 0xA5 then 0x3C on consecutive cycles -> two contiguous frames totalling 80 cycles; the second start bit begins on the cycle after the first stop bit ends.
- Overrun, baud_div=9, 6 consecutive writes 0x01..0x06 -> byte 1 popped so 0x01..0x05 accepted; tx_full asserted; 6th write sets tx_overrun for one cycle; only 5 frames transmitted, in order.
- Reset mid-frame, rst low during data bit 3 of 0xF0 with 2 bytes queued -> tx_pin high in the same cycle; tx_busy=0; no further frames after release.
- baud_div change: set 1 for the start bit, then 7 -> start bit 2 cycles, data bit 0 onward 8 cycles each.
- Parity, macro defined, PARITY_ODD=0, baud_div=1, byte 0x07 -> parity bit 1 between bit 7 and stop; frame 22 cycles. With PARITY_ODD=1 the parity bit is 0.
